// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg : shared codes and parameter checks for the dmem arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic OWNER_P = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rd_tag_pipe : {valid, owner} delay line matching the memory read latency
// Revision 1.0
// ---------------------------------------------------------------------------
module rd_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] owner_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      owner_q[0] <= in_owner;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_owner = owner_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arbiter : shares data_memory between processor (P) and loader (D)
// Revision 1.0
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic [1:0]        p_size,
  output logic              p_gnt,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_re,
  output logic              m_we,
  output logic [1:0]        m_size,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int               CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("dmem_arbiter: RD_LATENCY out of range 1..4");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve
    $error("dmem_arbiter: STARVE_LIMIT out of range 1..255");
  end

  logic [CNT_W-1:0] starve_cnt;
  logic             force_d;
  logic             tag_valid;
  logic             tag_owner;

  always_comb begin
    force_d = d_req & (starve_cnt == CNT_LIMIT);
    d_gnt   = ~reset & d_req & (~p_req | force_d);
    p_gnt   = ~reset & p_req & ~d_gnt;
    p_stall = ~reset & p_req & ~p_gnt;
  end

  // Idle bus is driven to all-zero so the memory sees no stale address.
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_size  = '0;
    m_re    = 1'b0;
    m_we    = 1'b0;
    if (d_gnt) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_size  = d_size;
      m_re    = ~d_we;
      m_we    = d_we;
    end else if (p_gnt) begin
      m_addr  = p_addr;
      m_wdata = p_wdata;
      m_size  = p_size;
      m_re    = ~p_we;
      m_we    = p_we;
    end
  end

  // A withdrawn D request forfeits its accumulated wait credit.
  always_ff @(posedge clock) begin
    if (reset || !d_req || d_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (m_re),
    .in_owner  (d_gnt ? OWNER_D : OWNER_P),
    .out_valid (tag_valid),
    .out_owner (tag_owner)
  );

  assign p_rvalid = ~reset & tag_valid & (tag_owner == OWNER_P);
  assign d_rvalid = ~reset & tag_valid & (tag_owner == OWNER_D);
  assign p_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : randomized bench with a behavioural arbiter/memory model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int RD_LATENCY   = 2;
  localparam int STARVE_LIMIT = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              p_req, p_we, d_req, d_we;
  logic [ADDR_W-1:0] p_addr, d_addr, m_addr;
  logic [DATA_W-1:0] p_wdata, d_wdata, m_wdata, m_rdata, p_rdata, d_rdata;
  logic [1:0]        p_size, d_size, m_size;
  logic              p_gnt, p_stall, p_rvalid, d_gnt, d_rvalid, m_re, m_we;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_size(p_size),
    .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_re(m_re), .m_we(m_we), .m_size(m_size),
    .m_rdata(m_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model state: memory contents, D wait time, in-flight reads.
  typedef struct packed {
    logic              valid;
    logic              owner;
    logic [DATA_W-1:0] data;
  } ret_t;

  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  ret_t              ret_q[$];
  int                waited = 0;
  bit                p_pend = 0, d_pend = 0;
  int                stall_seen = 0;

  // Directed field values, used when a step is not randomized.
  logic              dp_we, dd_we;
  logic [ADDR_W-1:0] dp_addr, dd_addr;
  logic [DATA_W-1:0] dp_wdata, dd_wdata;
  logic [1:0]        dp_size, dd_size;

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic step(input bit rst, input bit pr, input bit dr, input bit rnd);
    bit                e_pg, e_dg, e_stall, e_re, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic [1:0]        e_size;
    ret_t              front;
    @(negedge clock);
    reset = rst;
    if (rnd) begin
      if (!(p_pend && pr)) begin
        p_we = 1'($urandom); p_addr = 32'h1000_0000 + 4 * $urandom_range(0, 15);
        p_wdata = $urandom; p_size = 2'($urandom_range(0, 2));
      end
      if (!(d_pend && dr)) begin
        d_we = 1'($urandom); d_addr = 32'h1000_0000 + 4 * $urandom_range(0, 15);
        d_wdata = $urandom; d_size = 2'($urandom_range(0, 2));
      end
    end else begin
      p_we = dp_we; p_addr = dp_addr; p_wdata = dp_wdata; p_size = dp_size;
      d_we = dd_we; d_addr = dd_addr; d_wdata = dd_wdata; d_size = dd_size;
    end
    p_req = pr;
    d_req = dr;
    front = ret_q[0];
    m_rdata = front.valid ? front.data : $urandom;
    #1;
    // D wins when P is idle or when D has been turned away STARVE_LIMIT times in a row.
    e_dg    = !rst && dr && (!pr || waited >= STARVE_LIMIT);
    e_pg    = !rst && pr && !e_dg;
    e_stall = !rst && pr && !e_pg;
    e_addr = '0; e_wdata = '0; e_size = '0; e_re = 0; e_we = 0;
    if (e_dg) begin
      e_addr = d_addr; e_wdata = d_wdata; e_size = d_size; e_re = !d_we; e_we = d_we;
    end else if (e_pg) begin
      e_addr = p_addr; e_wdata = p_wdata; e_size = p_size; e_re = !p_we; e_we = p_we;
    end
    check("p_gnt", 64'(p_gnt), 64'(e_pg));
    check("d_gnt", 64'(d_gnt), 64'(e_dg));
    check("p_stall", 64'(p_stall), 64'(e_stall));
    check("m_re", 64'(m_re), 64'(e_re));
    check("m_we", 64'(m_we), 64'(e_we));
    check("m_addr", 64'(m_addr), 64'(e_addr));
    check("m_wdata", 64'(m_wdata), 64'(e_wdata));
    check("m_size", 64'(m_size), 64'(e_size));
    check("starve_cnt", 64'(dut.starve_cnt), 64'(waited));
    check("p_rvalid", 64'(p_rvalid), 64'(!rst && front.valid && front.owner == OWNER_P));
    check("d_rvalid", 64'(d_rvalid), 64'(!rst && front.valid && front.owner == OWNER_D));
    if (!rst && front.valid && front.owner == OWNER_P) check("p_rdata", 64'(p_rdata), 64'(front.data));
    if (!rst && front.valid && front.owner == OWNER_D) check("d_rdata", 64'(d_rdata), 64'(front.data));
    if (p_stall) stall_seen++;
    @(posedge clock);
    cyc++;
    void'(ret_q.pop_front());
    if (rst) begin
      waited = 0;
      foreach (ret_q[i]) ret_q[i] = '0;
      ret_q.push_back('0);
    end else begin
      waited = (!dr || e_dg) ? 0 : ((waited < STARVE_LIMIT) ? waited + 1 : STARVE_LIMIT);
      ret_q.push_back('{valid: e_re, owner: e_dg ? OWNER_D : OWNER_P, data: mem_rd(e_addr)});
      if (e_we) mem[e_addr] = e_wdata;
    end
    p_pend = pr && !e_pg;
    d_pend = dr && !e_dg;
  endtask

  initial begin
    for (int i = 0; i < RD_LATENCY; i++) ret_q.push_back('0);
    reset = 1; p_req = 0; d_req = 0; p_we = 0; d_we = 0;
    p_addr = '0; d_addr = '0; p_wdata = '0; d_wdata = '0; p_size = '0; d_size = '0;
    m_rdata = '0;
    dp_we = 0; dp_addr = '0; dp_wdata = '0; dp_size = SIZE_WORD;
    dd_we = 0; dd_addr = '0; dd_wdata = '0; dd_size = SIZE_WORD;

    // Reset with both requesters asking: nothing may be granted.
    repeat (3) step(1, 1, 1, 1);
    step(0, 0, 0, 1);

    // P-only read returning 0xDEADBEEF.
    mem[32'h1000_0010] = 32'hDEAD_BEEF;
    dp_we = 0; dp_addr = 32'h1000_0010;
    step(0, 1, 0, 0);
    repeat (RD_LATENCY + 1) step(0, 0, 0, 1);

    // Continuous contention: exactly one stall every STARVE_LIMIT+1 cycles.
    stall_seen = 0;
    repeat (5 * (STARVE_LIMIT + 1)) step(0, 1, 1, 1);
    check("stall_count", 64'(stall_seen), 64'(5));
    repeat (2) step(0, 0, 0, 1);

    // D-only byte write, no read return expected.
    dd_we = 1; dd_addr = 32'h1000_0020; dd_wdata = 32'h0000_00AA; dd_size = SIZE_BYTE;
    step(0, 0, 1, 0);
    repeat (RD_LATENCY + 1) step(0, 0, 0, 1);

    // Interleaved reads P, D, P with distinct data.
    mem[32'h1000_0004] = 32'h1111_1111;
    mem[32'h1000_0008] = 32'h2222_2222;
    mem[32'h1000_000C] = 32'h3333_3333;
    dp_we = 0; dd_we = 0; dp_size = SIZE_WORD; dd_size = SIZE_WORD;
    dp_addr = 32'h1000_0004; step(0, 1, 0, 0);
    dd_addr = 32'h1000_0008; step(0, 0, 1, 0);
    dp_addr = 32'h1000_000C; step(0, 1, 0, 0);
    repeat (RD_LATENCY + 1) step(0, 0, 0, 1);

    // D withdraws after 3 denials, then needs the full wait again.
    repeat (3) step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    repeat (STARVE_LIMIT + 2) step(0, 1, 1, 1);
    step(0, 0, 0, 1);

    // Reset right after a granted read discards it.
    dp_we = 0; dp_addr = 32'h1000_0010;
    step(0, 1, 0, 0);
    repeat (2) step(1, 1, 1, 1);
    repeat (RD_LATENCY + 2) step(0, 0, 0, 1);

    // Random traffic with varying load and occasional reset.
    for (int blk = 0; blk < 20; blk++) begin
      int pp, dp;
      pp = $urandom_range(0, 100);
      dp = $urandom_range(0, 100);
      repeat (100) step($urandom_range(0, 149) == 0, $urandom_range(0, 99) < pp,
                        $urandom_range(0, 99) < dp, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
